// File: rtl/lcv_mul_acc_pipe.sv
// Three-stage signed multiply-accumulate with running accumulator, per-op select,
// optional saturation and valid/ready flow control driven by one global enable.
module lcv_mul_acc_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 33,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_a,
  input  logic [IN_WIDTH-1:0]  in_b,
  input  logic [ACC_WIDTH-1:0] in_c,
  input  logic [1:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_sat
);

  localparam int PW = 2 * IN_WIDTH;
  localparam int RW = ACC_WIDTH + 2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_MAC   = 2'b01;
  localparam logic [1:0] OP_MSUB  = 2'b10;

  localparam logic signed [RW-1:0]        MAX_R = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0]        MIN_R = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] MAX_A = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_A = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  function automatic logic signed [RW-1:0] sext_prod(input logic signed [PW-1:0] v);
    return {{(RW-PW){v[PW-1]}}, v};
  endfunction

  function automatic logic signed [RW-1:0] sext_acc(input logic signed [ACC_WIDTH-1:0] v);
    return {{2{v[ACC_WIDTH-1]}}, v};
  endfunction

  // Returns {clamped_flag, final_value}.
  function automatic logic [ACC_WIDTH:0] sat_wrap(input logic signed [RW-1:0] r);
    if (SATURATE != 0) begin
      if (r > MAX_R) return {1'b1, MAX_A};
      if (r < MIN_R) return {1'b1, MIN_A};
    end
    return {1'b0, r[ACC_WIDTH-1:0]};
  endfunction

  logic en;

  logic vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic signed [IN_WIDTH-1:0]  a_p0_q, a_p0_d, b_p0_q, b_p0_d;
  logic signed [ACC_WIDTH-1:0] c_p0_q, c_p0_d, c_p1_q, c_p1_d;
  logic [1:0]                  op_p0_q, op_p0_d, op_p1_q, op_p1_d;
  logic signed [PW-1:0]        prod_p1_q, prod_p1_d;
  logic signed [ACC_WIDTH-1:0] sum_p2_q, sum_p2_d, acc_q, acc_d;
  logic                        sat_p2_q, sat_p2_d;

  logic signed [PW-1:0]        a_ext_p0, b_ext_p0;
  logic signed [RW-1:0]        prod_ext_p1, c_ext_p1, acc_ext, r_p2;
  logic [ACC_WIDTH:0]          fin_p2;

  assign a_ext_p0    = {{IN_WIDTH{a_p0_q[IN_WIDTH-1]}}, a_p0_q};
  assign b_ext_p0    = {{IN_WIDTH{b_p0_q[IN_WIDTH-1]}}, b_p0_q};
  assign prod_ext_p1 = sext_prod(prod_p1_q);
  assign c_ext_p1    = sext_acc(c_p1_q);
  assign acc_ext     = sext_acc(acc_q);

  // Stage 3 arithmetic: result at two guard bits, then clamp or wrap.
  always_comb begin
    r_p2 = '0;
    case (op_p1_q)
      OP_LOAD: r_p2 = prod_ext_p1 + c_ext_p1;
      OP_MAC:  r_p2 = acc_ext + prod_ext_p1 + c_ext_p1;
      OP_MSUB: r_p2 = acc_ext - prod_ext_p1 + c_ext_p1;
      default: r_p2 = '0;
    endcase
    fin_p2 = sat_wrap(r_p2);
  end

  assign en        = !(vld_p2_q && !out_ready);
  assign in_ready  = en;
  assign out_valid = vld_p2_q;
  assign out_sum   = sum_p2_q;
  assign out_sat   = sat_p2_q;

  always_comb begin
    vld_p0_d  = vld_p0_q;
    a_p0_d    = a_p0_q;
    b_p0_d    = b_p0_q;
    c_p0_d    = c_p0_q;
    op_p0_d   = op_p0_q;
    vld_p1_d  = vld_p1_q;
    prod_p1_d = prod_p1_q;
    c_p1_d    = c_p1_q;
    op_p1_d   = op_p1_q;
    vld_p2_d  = vld_p2_q;
    sum_p2_d  = sum_p2_q;
    sat_p2_d  = sat_p2_q;
    acc_d     = acc_q;
    if (en) begin
      // Stage 1: capture operands
      vld_p0_d  = in_valid;
      a_p0_d    = in_a;
      b_p0_d    = in_b;
      c_p0_d    = in_c;
      op_p0_d   = in_op;
      // Stage 2: product
      vld_p1_d  = vld_p0_q;
      prod_p1_d = a_ext_p0 * b_ext_p0;
      c_p1_d    = c_p0_q;
      op_p1_d   = op_p0_q;
      // Stage 3: result and accumulator, only when a real transaction arrives
      vld_p2_d  = vld_p1_q;
      if (vld_p1_q) begin
        sum_p2_d = fin_p2[ACC_WIDTH-1:0];
        sat_p2_d = fin_p2[ACC_WIDTH];
        acc_d    = fin_p2[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      sum_p2_q <= '0;
      sat_p2_q <= 1'b0;
      acc_q    <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      sum_p2_q <= sum_p2_d;
      sat_p2_q <= sat_p2_d;
      acc_q    <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    a_p0_q    <= a_p0_d;
    b_p0_q    <= b_p0_d;
    c_p0_q    <= c_p0_d;
    op_p0_q   <= op_p0_d;
    prod_p1_q <= prod_p1_d;
    c_p1_q    <= c_p1_d;
    op_p1_q   <= op_p1_d;
  end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// Bench for lcv_mul_acc_pipe: saturating and wrapping instances share stimulus and
// are scored against an arithmetic model of the accumulator.
module tb_lcv_mul_acc_pipe;
  localparam int IW = 16;
  localparam int AW = 33;
  localparam longint MAXV = 64'sd4294967295;
  localparam longint MINV = -64'sd4294967296;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready;
  logic [IW-1:0] in_a, in_b;
  logic [AW-1:0] in_c;
  logic [1:0]    in_op;
  logic          in_ready_s, out_valid_s, out_sat_s;
  logic          in_ready_w, out_valid_w, out_sat_w;
  logic [AW-1:0] out_sum_s, out_sum_w;

  lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s), .out_sat(out_sat_s));

  lcv_mul_acc_pipe #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_op(in_op),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w), .out_sat(out_sat_w));

  typedef struct {
    logic [1:0] op;
    longint     a, b, c;
    longint     exp_sum;
    bit         exp_sat;
  } vec_t;

  typedef struct {
    longint sum;
    bit     sat;
  } res_t;

  res_t   q_s[$], q_w[$];
  res_t   e_s, e_w;
  longint acc_s, acc_w;
  int     checks = 0, errors = 0;
  int     n_out = 0;
  bit     hold_pend = 1'b0;
  longint held_sum;
  vec_t   tbl[10];

  function automatic longint sv(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Accumulator arithmetic straight from the op definitions, in 64-bit integers.
  function automatic longint model(input logic [1:0] op, input longint a, input longint b,
                                   input longint c, input longint acc, input bit sat_en,
                                   output bit sat);
    longint p, r;
    p = a * b;
    case (op)
      2'b00:   r = p + c;
      2'b01:   r = acc + p + c;
      2'b10:   r = acc - p + c;
      default: r = 0;
    endcase
    sat = 1'b0;
    if (sat_en) begin
      if (r > MAXV) begin r = MAXV; sat = 1'b1; end
      else if (r < MINV) begin r = MINV; sat = 1'b1; end
    end else begin
      r = (r <<< 31) >>> 31;
    end
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input longint a, input longint b, input longint c,
                      input bit use_exp, input longint es, input bit esat, input bit rand_rdy);
    bit   acc_ok, s;
    res_t rs, rw;
    int   tries;
    if (rand_rdy && $urandom_range(0, 4) == 0) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a[IW-1:0];
    in_b     = b[IW-1:0];
    in_c     = c[AW-1:0];
    acc_ok   = 1'b0;
    tries    = 0;
    while (!acc_ok && tries < 100) begin
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc_ok = in_ready_s;
      @(posedge clk); #1;
      tries++;
    end
    in_valid = 1'b0;
    if (!acc_ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
    end else begin
      rs.sum = model(op, a, b, c, acc_s, 1'b1, s); rs.sat = s; acc_s = rs.sum;
      rw.sum = model(op, a, b, c, acc_w, 1'b0, s); rw.sat = s; acc_w = rw.sum;
      if (use_exp) begin rs.sum = es; rs.sat = esat; end
      q_s.push_back(rs);
      q_w.push_back(rw);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    q_s.delete(); q_w.delete();
    acc_s = 0; acc_w = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && (q_s.size() != 0 || q_w.size() != 0); k++) @(negedge clk);
    check("drain_pending", q_s.size() + q_w.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output scoreboard, hold-under-stall and in_ready-under-stall checks.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid_s, 1);
        check("hold_sum", sv(out_sum_s), held_sum);
      end
      if (out_valid_s && !out_ready) check("in_ready_stall", in_ready_s, 0);
      hold_pend = out_valid_s && !out_ready;
      held_sum  = sv(out_sum_s);
      if (out_valid_s && out_ready) begin
        n_out++;
        if (q_s.size() == 0) begin
          check("unexpected_out_s", sv(out_sum_s), -1);
        end else begin
          e_s = q_s.pop_front();
          check("sum_s", sv(out_sum_s), e_s.sum);
          check("sat_s", out_sat_s, e_s.sat);
        end
      end
      if (out_valid_w && out_ready) begin
        if (q_w.size() == 0) begin
          check("unexpected_out_w", sv(out_sum_w), -1);
        end else begin
          e_w = q_w.pop_front();
          check("sum_w", sv(out_sum_w), e_w.sum);
          check("sat_w", out_sat_w, e_w.sat);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n0;
    logic signed [IW-1:0] ra, rb;
    logic signed [AW-1:0] rc;
    logic [63:0] r64;
    logic [1:0]  rop;

    tbl[0] = '{2'b00, 2, 3, 0, 6, 1'b0};
    tbl[1] = '{2'b01, 4, 5, 1, 27, 1'b0};
    tbl[2] = '{2'b10, 1, 10, 0, 17, 1'b0};
    tbl[3] = '{2'b00, 10, 10, 0, 100, 1'b0};
    tbl[4] = '{2'b11, 7, 7, 9, 0, 1'b0};
    tbl[5] = '{2'b01, 2, 2, 0, 4, 1'b0};
    tbl[6] = '{2'b00, -32768, -32768, MAXV, MAXV, 1'b1};
    tbl[7] = '{2'b01, 1, 1, 0, MAXV, 1'b1};
    tbl[8] = '{2'b00, 0, 0, MINV, MINV, 1'b0};
    tbl[9] = '{2'b10, 1, 1, 0, MINV, 1'b1};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; in_op = 2'b00; out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_out_sum", sv(out_sum_s), 0);
    check("rst_out_sat", out_sat_s, 0);
    check("rst_in_ready", in_ready_s, 1);
    @(posedge clk); #1;

    // Single LOAD: latency and value.
    send(2'b00, 3, 4, 5, 1'b1, 17, 1'b0, 1'b0);
    lat = 0;
    while (!out_valid_s && lat < 10) begin @(negedge clk); lat++; end
    check("latency", lat, 3);
    drain();

    // Table of back-to-back transactions.
    do_reset();
    for (int i = 0; i < 10; i++)
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c, 1'b1, tbl[i].exp_sum, tbl[i].exp_sat, 1'b0);
    drain();

    // Wrap-mode overflow of the same LOAD, checked against a fixed value.
    do_reset();
    send(2'b00, -32768, -32768, MAXV, 1'b0, 0, 1'b0, 1'b0);
    lat = 0;
    while (!out_valid_w && lat < 10) begin @(negedge clk); lat++; end
    check("wrap_sum", sv(out_sum_w), -64'sd3221225473);
    check("wrap_sat", out_sat_w, 0);
    drain();

    // Six MACs with a four-cycle downstream stall in the middle.
    do_reset();
    n0 = n_out;
    fork
      begin
        send(2'b00, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) send(2'b01, 1, 1, 0, 1'b1, i, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_out_count", n_out - n0, 7);

    // Reset with transactions in flight.
    do_reset();
    send(2'b00, 5, 5, 0, 1'b0, 0, 1'b0, 1'b0);
    send(2'b01, 5, 5, 0, 1'b0, 0, 1'b0, 1'b0);
    send(2'b01, 5, 5, 0, 1'b0, 0, 1'b0, 1'b0);
    do_reset();
    check("flush_out_valid", out_valid_s, 0);
    n0 = n_out;
    repeat (5) @(posedge clk);
    #1;
    check("flush_no_output", n_out - n0, 0);
    send(2'b01, 1, 1, 0, 1'b1, 1, 1'b0, 1'b0);
    drain();
    check("flush_one_output", n_out - n0, 1);

    // Randomized ops, operands and backpressure against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      r64 = {$urandom, $urandom};
      rc  = r64[AW-1:0];
      if ($urandom_range(0, 2) == 0) rc = 33'($signed(16'($urandom)));
      rop = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) rop = 2'b11;
      else if (rop == 2'b11) rop = 2'b01;
      send(rop, longint'(ra), longint'(rb), longint'(rc), 1'b0, 0, 1'b0, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
